// File: rtl/ls_buffer_pkg.sv
// ls_buffer_pkg: opcodes, width codes, FSM states and the queue entry type
// shared by the load/store buffer and its load-extension helper.
package ls_buffer_pkg;

    localparam int ROB_W = 5;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } lsb_state_e;

    typedef struct packed {
        logic [31:0]      addr;
        logic [31:0]      data;
        logic             is_store;
        logic [2:0]       funct3;
        logic [ROB_W-1:0] rob_id;
    } lsb_entry_t;

endpackage

// File: rtl/ls_load_ext.sv
// ls_load_ext: sign/zero extension of raw LSB-aligned load data by Funct3.
module ls_load_ext
    import ls_buffer_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    // Byte/half loads extend from bit 7/15; word and unknown codes pass through.
    always_comb begin
        data = raw;
        case (funct3)
            F3_B:    data = {{24{raw[7]}}, raw[7:0]};
            F3_H:    data = {{16{raw[15]}}, raw[15:0]};
            F3_W:    data = raw;
            F3_BU:   data = {24'd0, raw[7:0]};
            F3_HU:   data = {16'd0, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/ls_buffer.sv
// ls_buffer: in-order load/store queue issuing its head to a single-outstanding
// memory port and broadcasting load results on the CDB.
// Optional feature: define LSB_IO_ORDER_EN to hold I/O-space loads
// (addr[17:16] == 2'b11) at the head until they are the oldest ROB entry.
module ls_buffer
    import ls_buffer_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rst_c,
    input  logic             rdy,
    input  logic             en_i,
    input  logic [31:0]      A_i,
    input  logic [31:0]      B_i,
    input  logic [31:0]      Imm_i,
    input  logic [6:0]       OP_i,
    input  logic [2:0]       Funct3_i,
    input  logic [ROB_W-1:0] ROB_id_i,
    output logic             full_o,
    input  logic [ROB_W-1:0] rob_head_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [1:0]       mem_size_o,
    input  logic             mem_done_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             cdb_en_o,
    output logic [ROB_W-1:0] cdb_id_ROB_o,
    output logic [31:0]      cdb_data_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    lsb_entry_t       q [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    lsb_state_e       state;

    lsb_entry_t       head;
    logic             head_vld;
    logic             push, pop;
    logic             needs_order, issue_ok;
    logic [31:0]      ext_data;

    assign head     = q[rd_ptr];
    assign head_vld = (count != '0);

    // One slot is kept spare for the reservation station's issue latency.
    assign full_o = (count >= CNT_W'(DEPTH - 1));

    // A write arriving with every slot occupied is dropped; a flush cycle accepts nothing.
    assign push = rdy && en_i && !rst_c && (count != CNT_W'(DEPTH));
    assign pop  = rdy && !rst_c && (state == ST_BUSY) && mem_done_i;

    // Stores (and optionally I/O loads) must wait until they are the oldest in the ROB.
    always_comb begin
        needs_order = head.is_store;
`ifdef LSB_IO_ORDER_EN
        if (!head.is_store && (head.addr[17:16] == 2'b11))
            needs_order = 1'b1;
`endif
        issue_ok = !needs_order || (rob_head_i == head.rob_id);
    end

    ls_load_ext u_ext (
        .funct3 (head.funct3),
        .raw    (mem_rdata_i),
        .data   (ext_data)
    );

    // Entry storage: no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push)
            q[wr_ptr] <= '{addr:     A_i + Imm_i,
                           data:     B_i,
                           is_store: (OP_i == OP_STORE),
                           funct3:   Funct3_i,
                           rob_id:   ROB_id_i};
    end

    // Queue pointers and occupancy; a flush empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (rdy) begin
            if (rst_c) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Issue FSM with registered memory and CDB outputs.
    // The CDB strobe is a pulse, so it falls even while rdy is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_size_o   <= '0;
            cdb_en_o     <= 1'b0;
            cdb_id_ROB_o <= '0;
            cdb_data_o   <= '0;
        end else begin
            cdb_en_o <= 1'b0;
            if (rdy) begin
                case (state)
                    ST_IDLE: begin
                        if (!rst_c && head_vld && issue_ok) begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= head.is_store;
                            mem_addr_o  <= head.addr;
                            mem_wdata_o <= head.data;
                            mem_size_o  <= head.funct3[1:0];
                            state       <= ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        if (mem_done_i) begin
                            mem_req_o <= 1'b0;
                            state     <= ST_IDLE;
                            if (!head.is_store && !rst_c) begin
                                cdb_en_o     <= 1'b1;
                                cdb_id_ROB_o <= head.rob_id;
                                cdb_data_o   <= ext_data;
                            end
                        end else if (rst_c) begin
                            // Memory still owes a response; swallow it in DRAIN.
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (mem_done_i) begin
                            mem_req_o <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ls_buffer.sv
// tb_ls_buffer: scoreboard bench for ls_buffer. Stimulus pushes expected memory
// requests; a memory responder answers; a negedge monitor pops and compares.
module tb_ls_buffer;
    import ls_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, rst_c = 1'b0, rdy = 1'b1, en_i = 1'b0;
    logic [31:0] A_i = '0, B_i = '0, Imm_i = '0;
    logic [6:0]  OP_i = '0;
    logic [2:0]  Funct3_i = '0;
    logic [4:0]  ROB_id_i = '0, rob_head_i = '0;
    logic        full_o, mem_req_o, mem_we_o, mem_done_i, cdb_en_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, cdb_data_o;
    logic [1:0]  mem_size_o;
    logic [4:0]  cdb_id_ROB_o;

    ls_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rst_c(rst_c), .rdy(rdy), .en_i(en_i),
        .A_i(A_i), .B_i(B_i), .Imm_i(Imm_i), .OP_i(OP_i), .Funct3_i(Funct3_i),
        .ROB_id_i(ROB_id_i), .full_o(full_o), .rob_head_i(rob_head_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
        .mem_done_i(mem_done_i), .mem_rdata_i(mem_rdata_i),
        .cdb_en_o(cdb_en_o), .cdb_id_ROB_o(cdb_id_ROB_o), .cdb_data_o(cdb_data_o)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    typedef struct { bit st; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata; logic [4:0] rob; } ent_t;
    typedef struct { logic [4:0] rob; logic [31:0] data; } cdb_t;

    ent_t       exp_req[$];
    cdb_t       exp_cdb[$];
    ent_t       infl;
    bit         infl_vld = 0, infl_flushed = 0;
    int         mcount = 0;
    int         cdb_seen = 0;
    logic [4:0] last_rob_head = '0;
    bit         prev_req = 0;
    bit         mem_stall = 0, rd_force_en = 0;
    logic [31:0] rd_force = '0;
    bit         done_eff, do_pop;
    int         old_cnt;

    // Load result as the architecture defines it, in plain arithmetic.
    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] r);
        case (f3)
            3'd0:    return (r & 32'hFF)   - (r[7]  ? 32'h100   : 32'h0);
            3'd1:    return (r & 32'hFFFF) - (r[15] ? 32'h10000 : 32'h0);
            3'd4:    return r & 32'hFF;
            3'd5:    return r & 32'hFFFF;
            default: return r;
        endcase
    endfunction

    // Reference model: queue occupancy, accepted entries, expected broadcasts.
    always @(posedge clk) begin
        if (rst_n && rdy) begin
            last_rob_head = rob_head_i;
            old_cnt = mcount;
            done_eff = mem_done_i && mem_req_o && infl_vld;
            do_pop = 0;
            if (done_eff) begin
                if (!infl_flushed && !rst_c) begin
                    do_pop = 1;
                    if (!infl.st) exp_cdb.push_back('{infl.rob, ext(infl.f3, mem_rdata_i)});
                end
                infl_vld = 0;
                infl_flushed = 0;
            end
            if (rst_c) begin
                mcount = 0;
                exp_req.delete();
                if (infl_vld) infl_flushed = 1;
            end else begin
                if (en_i && old_cnt < DEPTH) begin
                    exp_req.push_back('{OP_i == OP_STORE, Funct3_i, A_i + Imm_i, B_i, ROB_id_i});
                    mcount++;
                end
                if (do_pop) mcount--;
            end
        end
    end

    // Monitor: compare DUT outputs against the scoreboard away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("full_o", {31'd0, full_o}, {31'd0, mcount >= DEPTH - 1});
            if (mem_req_o && !prev_req) begin
                if (exp_req.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got request addr 0x%08h expected none", mem_addr_o);
                end else begin
                    infl = exp_req.pop_front();
                    infl_vld = 1;
                    infl_flushed = 0;
                    check("req_we",   {31'd0, mem_we_o}, {31'd0, infl.st});
                    check("req_addr", mem_addr_o, infl.addr);
                    check("req_size", {30'd0, mem_size_o}, {30'd0, infl.f3[1:0]});
                    if (infl.st) begin
                        check("req_wdata", mem_wdata_o, infl.wdata);
                        check("store_rob_order", {27'd0, last_rob_head}, {27'd0, infl.rob});
                    end
`ifdef LSB_IO_ORDER_EN
                    else if (infl.addr[17:16] == 2'b11)
                        check("io_rob_order", {27'd0, last_rob_head}, {27'd0, infl.rob});
`endif
                end
            end else if (mem_req_o && infl_vld) begin
                check("hold_addr", mem_addr_o, infl.addr);
                check("hold_we",   {31'd0, mem_we_o}, {31'd0, infl.st});
            end
            if (cdb_en_o) begin
                cdb_seen++;
                if (exp_cdb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cdb: got rob %0d data 0x%08h expected none", cdb_id_ROB_o, cdb_data_o);
                end else begin
                    cdb_t c;
                    c = exp_cdb.pop_front();
                    check("cdb_rob",  {27'd0, cdb_id_ROB_o}, {27'd0, c.rob});
                    check("cdb_data", cdb_data_o, c.data);
                end
            end
            prev_req = mem_req_o;
        end
    end

    // Memory responder: random latency, one-cycle done pulses, optional stall.
    initial begin
        mem_done_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            mem_done_i = 1'b0;
            if (mem_req_o && !mem_stall && $urandom_range(0, 2) == 0) begin
                mem_done_i = 1'b1;
                mem_rdata_i = rd_force_en ? rd_force : $urandom();
            end
        end
    end

    // Present one entry for exactly one clock edge; called just after an edge.
    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] imm, input logic [31:0] b, input logic [4:0] rob);
        en_i = 1'b1;
        OP_i = st ? OP_STORE : OP_LOAD;
        Funct3_i = f3; A_i = a; Imm_i = imm; B_i = b; ROB_id_i = rob;
        @(posedge clk); #1;
        en_i = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int maxc, input bit spin_rob);
        for (int i = 0; i < maxc; i++) begin
            if (spin_rob) rob_head_i = 5'(i % 4);
            @(posedge clk); #1;
            if (exp_req.size() == 0 && exp_cdb.size() == 0 && !infl_vld && !mem_req_o) return;
        end
        checks++; errors++;
        $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_req.size() + exp_cdb.size());
    endtask

    logic [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int cdb_before;
    bit st;

    initial begin
        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_full",  {31'd0, full_o}, 32'd0);
        check("rst_req",   {31'd0, mem_req_o}, 32'd0);
        check("rst_we",    {31'd0, mem_we_o}, 32'd0);
        check("rst_addr",  mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_size",  {30'd0, mem_size_o}, 32'd0);
        check("rst_cdb",   {31'd0, cdb_en_o}, 32'd0);
        check("rst_cdbid", {27'd0, cdb_id_ROB_o}, 32'd0);
        check("rst_cdbd",  cdb_data_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LW 0x100+4, LB/LBU of 0x80.
        rd_force_en = 1; rd_force = 32'hDEADBEEF;
        issue(0, F3_W, 32'h100, 32'd4, 32'h0, 5'd1);
        wait_empty("lw", 100, 0);
        rd_force = 32'h80;
        issue(0, F3_B, 32'h40, 32'd1, 32'h0, 5'd2);
        wait_empty("lb", 100, 0);
        issue(0, F3_BU, 32'h40, 32'd2, 32'h0, 5'd3);
        wait_empty("lbu", 100, 0);
        rd_force_en = 0;

        // SW must wait for its ROB turn and broadcast nothing.
        rob_head_i = 5'd2;
        cdb_before = cdb_seen;
        issue(1, F3_W, 32'h200, 32'd8, 32'hCAFEF00D, 5'd3);
        repeat (6) begin
            @(negedge clk);
            check("store_wait_req", {31'd0, mem_req_o}, 32'd0);
        end
        @(posedge clk); #1;
        rob_head_i = 5'd3;
        wait_empty("sw", 100, 0);
        check("store_no_cdb", cdb_seen, cdb_before);

        // Four back-to-back loads with memory stalled, then one that must drop.
        mem_stall = 1;
        issue(0, F3_W, 32'h1000, 32'd0, 32'h0, 5'd4);
        issue(0, F3_H, 32'h1000, 32'd2, 32'h0, 5'd5);
        check("full_at_2", {31'd0, full_o}, 32'd0);
        issue(0, F3_HU, 32'h1000, 32'd4, 32'h0, 5'd6);
        check("full_at_3", {31'd0, full_o}, 32'd1);
        issue(0, F3_B, 32'h1000, 32'd6, 32'h0, 5'd7);
        check("full_at_4", {31'd0, full_o}, 32'd1);
        issue(0, F3_W, 32'h2000, 32'd0, 32'h0, 5'd8);
        mem_stall = 0;
        wait_empty("full", 400, 0);

        // Flush while a load is outstanding.
        mem_stall = 1;
        cdb_before = cdb_seen;
        issue(0, F3_W, 32'h300, 32'd0, 32'h0, 5'd9);
        for (int i = 0; i < 20 && !mem_req_o; i++) begin @(posedge clk); #1; end
        issue(0, F3_W, 32'h304, 32'd0, 32'h0, 5'd10);
        rst_c = 1'b1;
        @(posedge clk); #1;
        rst_c = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("drain_req_held", {31'd0, mem_req_o}, 32'd1);
        end
        @(posedge clk); #1;
        mem_stall = 0;
        for (int i = 0; i < 50 && mem_req_o; i++) begin @(posedge clk); #1; end
        repeat (6) begin
            @(negedge clk);
            check("flush_empty_req", {31'd0, mem_req_o}, 32'd0);
        end
        check("flush_no_cdb", cdb_seen, cdb_before);
        @(posedge clk); #1;

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            st = ($urandom_range(0, 2) == 0);
            en_i = ($urandom_range(0, 1) == 0);
            OP_i = st ? OP_STORE : OP_LOAD;
            Funct3_i = st ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
            A_i = $urandom(); Imm_i = $urandom(); B_i = $urandom();
            ROB_id_i = 5'($urandom_range(0, 3));
            rob_head_i = 5'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 9) != 0);
            rst_c = ($urandom_range(0, 59) == 0);
            mem_stall = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        en_i = 1'b0; rst_c = 1'b0; rdy = 1'b1; mem_stall = 0;
        wait_empty("random_drain", 800, 1);
        check("left_req", exp_req.size(), 32'd0);
        check("left_cdb", exp_cdb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ls_buffer.md
LS_BUFFER -- requirements
Module: ls_buffer

Interface
REQ-001 SHALL have parameter DEPTH, 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  clock; all state changes occur on the rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port rst_c  in  1  synchronous pipeline flush (branch mispredict).
REQ-005 SHALL have port rdy  in  1  global enable; when low, all state holds.
REQ-006 SHALL have port en_i  in  1  entry valid from the load/store reservation station.
REQ-007 SHALL have port A_i  in  32  base register value.
REQ-008 SHALL have port B_i  in  32  store data.
REQ-009 SHALL have port Imm_i  in  32  sign-extended offset.
REQ-010 SHALL have port OP_i  in  7  opcode: 7'b0000011 load, 7'b0100011 store.
REQ-011 SHALL have port Funct3_i  in  3  width/sign code.
REQ-012 SHALL have port ROB_id_i  in  5  ROB tag.
REQ-013 SHALL have port full_o  out  1  backpressure to the reservation station.
REQ-014 SHALL have port rob_head_i  in  5  tag of the oldest uncommitted ROB entry.
REQ-015 SHALL have port mem_req_o  out  1  memory request, held until done.
REQ-016 SHALL have port mem_we_o  out  1  1 = store.
REQ-017 SHALL have port mem_addr_o  out  32  byte address.
REQ-018 SHALL have port mem_wdata_o  out  32  store data, LSB-aligned.
REQ-019 SHALL have port mem_size_o  out  2  0 = byte, 1 = half, 2 = word.
REQ-020 SHALL have port mem_done_i  in  1  one-cycle completion pulse; mem_rdata_i valid.
REQ-021 SHALL have port mem_rdata_i  in  32  raw load data.
REQ-022 SHALL have ports cdb_en_o (out, 1), cdb_id_ROB_o (out, 5) and cdb_data_o (out, 32) forming the result broadcast, with cdb_en_o high for exactly one cycle per load.

Function
REQ-023 SHALL enqueue in order when en_i && rdy: addr = A_i + Imm_i (mod 2^32), B_i, OP, Funct3, ROB id.
REQ-024 SHALL assert full_o when count >= DEPTH-1, leaving one slot for the reservation station's one-cycle issue latency; an en_i received while count == DEPTH SHALL be dropped.
REQ-025 SHALL implement an FSM with states IDLE, BUSY and DRAIN; only the queue head is ever issued.
REQ-026 In IDLE with the head valid, a load SHALL issue immediately and a store SHALL issue only when rob_head_i == head ROB id; on issue, mem_req_o goes high in the next cycle and the FSM moves to BUSY.
REQ-027 In BUSY, outputs SHALL hold stable until mem_done_i; on done the head pops and the FSM returns to IDLE, giving at least one idle cycle between requests.
REQ-028 On load done, cdb_en_o SHALL pulse on the next cycle with the ROB id and extended data: LB 000 and LH 001 sign-extend, LW 010 passes through, LBU 100 and LHU 101 zero-extend.
REQ-029 mem_size_o SHALL equal Funct3[1:0], and a store SHALL produce no CDB broadcast.
REQ-030 Enqueue and dequeue in the same cycle SHALL leave count unchanged; read and write pointers wrap modulo DEPTH.
REQ-031 rst_c SHALL clear the queue and suppress a pending cdb_en_o; if the FSM is in BUSY, it SHALL enter DRAIN and wait for mem_done_i, discarding the result, before returning to IDLE.

Reset
REQ-032 While rst_n is low: queue empty, FSM in IDLE, full_o=0, mem_req_o=0, mem_we_o=0, cdb_en_o=0, and all data outputs 0.
REQ-033 Assertion of rst_n mid-transaction SHALL abandon the transaction without DRAIN.

Configuration
REQ-034 With LSB_IO_ORDER_EN defined, a load at the head whose addr[17:16] == 2'b11 (I/O space, 0x30000 and above) SHALL wait for rob_head_i == its ROB id before issue; without the macro, all loads issue per REQ-026.

Structure
REQ-035 A shared package SHALL hold the opcodes, the Funct3 codes, the FSM state enum and ROB_W=5; a sub-module ls_load_ext SHALL perform the load extension.

Verification
REQ-036 The bench SHALL cover: LW with A=0x100, Imm=4 -> mem_addr_o=0x104, size 2; done with rdata 0xDEADBEEF -> CDB 0xDEADBEEF.
REQ-037 The bench SHALL cover: LB with rdata 0x80 -> CDB 0xFFFFFF80; LBU with rdata 0x80 -> CDB 0x00000080.
REQ-038 The bench SHALL cover: SW with ROB id 3 while rob_head_i=2 -> no mem_req_o; then rob_head_i=3 -> request with we=1, no CDB.
REQ-039 The bench SHALL cover: four back-to-back enqueues with memory stalled -> full_o high at count 3 and the fourth entry still accepted.
REQ-040 The bench SHALL cover: rst_c during a BUSY load -> no cdb_en_o, mem_req_o held until mem_done_i, then the queue is empty.
